commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
Hardware commit-trace recorder that sits directly downstream of the 16-bit cpu core. It samples the core's per-cycle commit signals: PC, fetched instruction, register-file write port, data-memory port and hlt. Each sample is classified into a trace record, stamped with a sequence number and queued in a FIFO. A host or a testbench drains the FIFO. The block also maintains cycle and instruction statistics, stops on halt, and raises a watchdog timeout.

Parameters:
DEPTH, 16, number of FIFO record entries (power of 2, >=2)
CYCLE_LIMIT, 100000, run cycles after which the watchdog fires

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
pc  in  16  PC of the committing instruction
inst  in  16  instruction word
reg_write  in  1  register file written this cycle
write_reg  in  4  destination register
write_data  in  16  register write data
mem_read  in  1  data memory read this cycle
mem_write  in  1  data memory write this cycle
mem_addr  in  16  data memory address
mem_data  in  16  store data
hlt  in  1  halt reached memory/writeback
rd_en  in  1  pop the head record
rec_valid  out  1  FIFO non-empty; head record fields valid
rec_kind  out  3  0=NOP/branch, 1=REG, 2=LOAD, 3=STORE, 4=HALT
rec_inum  out  16  record sequence number
rec_pc  out  16  captured pc
rec_inst  out  16  captured inst
rec_reg  out  4  captured write_reg (REG/LOAD only; else 0)
rec_addr  out  16  captured mem_addr (LOAD/STORE only; else 0)
rec_value  out  16  write_data (REG/LOAD) or mem_data (STORE); else 0
cycle_count  out  32  run cycles since reset release
inst_count  out  16  records generated, including dropped records
drop_count  out  8  records dropped because the FIFO was full; saturates at 255
overflow  out  1  sticky; set on the first drop
halted  out  1  HALT record generated
timeout  out  1  watchdog fired

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO emptied; all counters 0; overflow, halted and timeout cleared.
  - State goes to RUN. rec_* outputs read 0 while rec_valid=0.
- States:
  - RUN: capture every cycle.
  - HALTED: no capture; counters frozen; FIFO drain continues.
  - TIMEOUT: same as HALTED, with timeout=1.
  - HALTED and TIMEOUT are left only via reset.
- RUN, each cycle:
  - cycle_count increments.
  - One record is generated.
  - inst_count increments.
  - Record inum = inst_count value before the increment; the first record has inum 0.
- Classification, priority order:
  1. reg_write & mem_read -> LOAD
  2. reg_write -> REG
  3. hlt -> HALT
  4. mem_write -> STORE
  5. otherwise NOP
- HALT record: on the next edge the state goes to HALTED and halted=1.
- Watchdog: when cycle_count would become CYCLE_LIMIT+1, no record is generated that cycle. State goes to TIMEOUT, timeout=1, cycle_count holds at CYCLE_LIMIT.
- FIFO:
  - First-word-fall-through; head fields are registered outputs.
  - Write and read pointers are log2(DEPTH) wide plus one wrap bit. Full and empty are decided by the wrap bit.
  - Write latency: a record captured at edge N is visible on rec_* after edge N when the FIFO was empty.
- Pop: rd_en & rec_valid pops at the edge. rd_en while empty is ignored; no underflow and no state change.
- Full, no pop: the new record is dropped.
  - inst_count still increments, so dropped inum values leave a gap.
  - drop_count increments (saturating); overflow=1.
  - A dropped HALT record still moves the state to HALTED.
- Full with a pop in the same cycle: the pop and the write both occur; no drop.
- Counters: inst_count wraps modulo 2^16; cycle_count never exceeds CYCLE_LIMIT.
- Reset mid-operation, including mid-drain: all records are discarded; no partial state remains.

Test Plan:
1. Reset release, then 3 NOP cycles with rd_en=0 -> 3 records with kind=0 and inum 0,1,2; cycle_count=3; inst_count=3.
2. Commit reg_write=1, write_reg=5, write_data=0x1234, mem_read=1, mem_addr=0x0040 -> record LOAD, rec_reg=5, rec_value=0x1234, rec_addr=0x0040.
3. Commit mem_write=1, mem_addr=0x0010, mem_data=0xBEEF, then hlt=1 while reg_write=0 -> records STORE then HALT; halted=1 on the next edge. Further inputs create no records; the FIFO drains 2 entries, then rec_valid=0.
4. DEPTH=16 with rd_en=0 for 20 RUN cycles -> 16 records (inum 0..15); drop_count=4; overflow=1; inst_count=20. Enabling rd_en yields inum 0..15 in order.
5. FIFO full, then rd_en=1 on every cycle while capturing -> no further drops; occupancy stays at 16.
6. CYCLE_LIMIT=8 with no hlt -> 8 records; timeout=1; cycle_count=8. Asserting rst_n=0 for one cycle clears all outputs to 0.

Source files
------------

// File: rtl/commit_trace_buffer_if.sv
// Bundles the commit-side sample, the drain handshake and the statistics
// of the commit trace buffer. The buffer is the slave; the core and host side is the master.
interface commit_trace_buffer_if;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        reg_write;
  logic [3:0]  write_reg;
  logic [15:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        hlt;
  logic        rd_en;
  logic        rec_valid;
  logic [2:0]  rec_kind;
  logic [15:0] rec_inum;
  logic [15:0] rec_pc;
  logic [15:0] rec_inst;
  logic [3:0]  rec_reg;
  logic [15:0] rec_addr;
  logic [15:0] rec_value;
  logic [31:0] cycle_count;
  logic [15:0] inst_count;
  logic [7:0]  drop_count;
  logic        overflow;
  logic        halted;
  logic        timeout;

  modport master (
    output pc, inst, reg_write, write_reg, write_data, mem_read, mem_write,
           mem_addr, mem_data, hlt, rd_en,
    input  rec_valid, rec_kind, rec_inum, rec_pc, rec_inst, rec_reg, rec_addr,
           rec_value, cycle_count, inst_count, drop_count, overflow, halted, timeout
  );

  modport slave (
    input  pc, inst, reg_write, write_reg, write_data, mem_read, mem_write,
           mem_addr, mem_data, hlt, rd_en,
    output rec_valid, rec_kind, rec_inum, rec_pc, rec_inst, rec_reg, rec_addr,
           rec_value, cycle_count, inst_count, drop_count, overflow, halted, timeout
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit-trace recorder: classifies each committed cycle into a record, numbers it
// and queues it in a first-word-fall-through FIFO, with run statistics and a watchdog.
module commit_trace_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CYCLE_LIMIT = 100000
) (
  input logic                  clk,
  input logic                  rst_n,
  commit_trace_buffer_if.slave bus
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  localparam logic [2:0] K_NOP   = 3'd0;
  localparam logic [2:0] K_REG   = 3'd1;
  localparam logic [2:0] K_LOAD  = 3'd2;
  localparam logic [2:0] K_STORE = 3'd3;
  localparam logic [2:0] K_HALT  = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [15:0] inst;
    logic [3:0]  rreg;
    logic [15:0] addr;
    logic [15:0] value;
  } rec_t;

  state_e      state_q, state_d;
  rec_t        mem_q [DEPTH];
  rec_t        mem_d [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  rec_t        head_q, head_d;
  logic        rec_valid_q, rec_valid_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [15:0] inst_count_q, inst_count_d;
  logic [7:0]  drop_count_q, drop_count_d;
  logic        overflow_q, overflow_d;
  logic        halted_q, halted_d;
  logic        timeout_q, timeout_d;

  rec_t new_rec_s;
  logic gen_s;
  logic full_s;
  logic empty_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  // Classify the current commit sample; fields that do not apply to the kind stay zero.
  always_comb begin
    new_rec_s      = '0;
    new_rec_s.inum = inst_count_q;
    new_rec_s.pc   = bus.pc;
    new_rec_s.inst = bus.inst;
    if (bus.reg_write && bus.mem_read) begin
      new_rec_s.kind  = K_LOAD;
      new_rec_s.rreg  = bus.write_reg;
      new_rec_s.addr  = bus.mem_addr;
      new_rec_s.value = bus.write_data;
    end else if (bus.reg_write) begin
      new_rec_s.kind  = K_REG;
      new_rec_s.rreg  = bus.write_reg;
      new_rec_s.value = bus.write_data;
    end else if (bus.hlt) begin
      new_rec_s.kind  = K_HALT;
    end else if (bus.mem_write) begin
      new_rec_s.kind  = K_STORE;
      new_rec_s.addr  = bus.mem_addr;
      new_rec_s.value = bus.mem_data;
    end else begin
      new_rec_s.kind  = K_NOP;
    end
  end

  // Run-state sequencing, statistics, and the FIFO pointer/head next-state.
  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    inst_count_d  = inst_count_q;
    drop_count_d  = drop_count_q;
    overflow_d    = overflow_q;
    halted_d      = halted_q;
    timeout_d     = timeout_q;
    gen_s         = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (cycle_count_q == 32'(CYCLE_LIMIT)) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
        end else begin
          gen_s         = 1'b1;
          cycle_count_d = cycle_count_q + 32'd1;
          inst_count_d  = inst_count_q + 16'd1;
          if (new_rec_s.kind == K_HALT) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            state_d  = ST_RUN;
          end
        end
      end
      ST_HALTED:  state_d = ST_HALTED;
      ST_TIMEOUT: state_d = ST_TIMEOUT;
      default:    state_d = ST_HALTED;
    endcase

    full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    empty_s = (wptr_q == rptr_q);
    pop_s   = bus.rd_en && !empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the record.
    push_s  = gen_s && (!full_s || pop_s);
    drop_s  = gen_s && full_s && !pop_s;

    if (drop_s) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) begin
        drop_count_d = drop_count_q + 8'd1;
      end else begin
        drop_count_d = drop_count_q;
      end
    end else begin
      overflow_d   = overflow_q;
    end

    mem_d = mem_q;
    if (push_s) begin
      mem_d[wptr_q[AW-1:0]] = new_rec_s;
      wptr_d                = wptr_q + PTR_ONE;
    end else begin
      wptr_d                = wptr_q;
    end

    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end

    rec_valid_d = (wptr_d != rptr_d);
    // The new head is the record being written only when it lands in the slot just reached.
    if (!rec_valid_d) begin
      head_d = '0;
    end else if (push_s && (rptr_d == wptr_q)) begin
      head_d = new_rec_s;
    end else begin
      head_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  // Control, statistics and head registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wptr_q        <= '0;
      rptr_q        <= '0;
      head_q        <= '0;
      rec_valid_q   <= 1'b0;
      cycle_count_q <= 32'd0;
      inst_count_q  <= 16'd0;
      drop_count_q  <= 8'd0;
      overflow_q    <= 1'b0;
      halted_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      head_q        <= head_d;
      rec_valid_q   <= rec_valid_d;
      cycle_count_q <= cycle_count_d;
      inst_count_q  <= inst_count_d;
      drop_count_q  <= drop_count_d;
      overflow_q    <= overflow_d;
      halted_q      <= halted_d;
      timeout_q     <= timeout_d;
    end
  end

  // Record storage; contents are unobservable past the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.rec_valid   = rec_valid_q;
  assign bus.rec_kind    = head_q.kind;
  assign bus.rec_inum    = head_q.inum;
  assign bus.rec_pc      = head_q.pc;
  assign bus.rec_inst    = head_q.inst;
  assign bus.rec_reg     = head_q.rreg;
  assign bus.rec_addr    = head_q.addr;
  assign bus.rec_value   = head_q.value;
  assign bus.cycle_count = cycle_count_q;
  assign bus.inst_count  = inst_count_q;
  assign bus.drop_count  = drop_count_q;
  assign bus.overflow    = overflow_q;
  assign bus.halted      = halted_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: stimulus steps a queue-based reference
// model and pushes expected records; a monitor pops and compares on every DUT pop.
module tb_commit_trace_buffer;
  localparam int DEPTH = 16;
  localparam int LIMIT = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  commit_trace_buffer_if bus();

  commit_trace_buffer #(.DEPTH(DEPTH), .CYCLE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] pc, inst, wd, ma, md;
    logic [3:0]  wr;
    logic        rw, mr, mw, hlt;
  } cin_t;

  typedef struct {
    int kind, inum, pc, inst, rreg, addr, value;
  } rec_t;

  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_en      = 1'b0;
  rec_t sb[$];

  // Reference model state (after all edges issued so far) and its pre-edge snapshot.
  int m_cyc, m_inst, m_drop, m_cnt;
  bit m_ovf, m_halt, m_to;
  int s_cyc, s_inst, s_drop, s_cnt;
  bit s_ovf, s_halt, s_to;

  function automatic rec_t classify(cin_t c, int inum);
    rec_t r;
    r = '{default: 0};
    r.inum = inum;
    r.pc   = int'(c.pc);
    r.inst = int'(c.inst);
    if (c.rw && c.mr) begin
      r.kind = 2; r.rreg = int'(c.wr); r.addr = int'(c.ma); r.value = int'(c.wd);
    end else if (c.rw) begin
      r.kind = 1; r.rreg = int'(c.wr); r.value = int'(c.wd);
    end else if (c.hlt) begin
      r.kind = 4;
    end else if (c.mw) begin
      r.kind = 3; r.addr = int'(c.ma); r.value = int'(c.md);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_inst = 0; m_drop = 0; m_cnt = 0;
    m_ovf = 0; m_halt = 0; m_to = 0;
    sb.delete();
  endtask

  task automatic model_step(cin_t c, bit rd);
    rec_t r;
    if (rd && m_cnt > 0) m_cnt--;
    if (!m_halt && !m_to) begin
      if (m_cyc == LIMIT) begin
        m_to = 1;
      end else begin
        m_cyc++;
        r = classify(c, m_inst);
        m_inst = (m_inst + 1) % 65536;
        if (m_cnt < DEPTH) begin
          m_cnt++;
          sb.push_back(r);
        end else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
        if (r.kind == 4) m_halt = 1;
      end
    end
  endtask

  function automatic cin_t rand_cin(int hlt_pct);
    cin_t c;
    c.pc  = 16'($urandom);  c.inst = 16'($urandom);
    c.wd  = 16'($urandom);  c.ma   = 16'($urandom);
    c.md  = 16'($urandom);  c.wr   = 4'($urandom);
    c.rw  = ($urandom_range(0, 2) == 0);
    c.mr  = ($urandom_range(0, 1) == 0);
    c.mw  = ($urandom_range(0, 2) == 0);
    c.hlt = ($urandom_range(0, 99) < hlt_pct);
    return c;
  endfunction

  function automatic cin_t nop_c();
    cin_t c;
    c = rand_cin(0);
    c.rw = 1'b0; c.mr = 1'b0; c.mw = 1'b0; c.hlt = 1'b0;
    return c;
  endfunction

  // One clock of stimulus: drive at the falling edge, then predict the next rising edge.
  task automatic drive(cin_t c, bit rd, bit rst);
    @(negedge clk);
    s_cyc = m_cyc; s_inst = m_inst; s_drop = m_drop; s_cnt = m_cnt;
    s_ovf = m_ovf; s_halt = m_halt; s_to = m_to;
    rst_n          = ~rst;
    bus.pc         = c.pc;        bus.inst      = c.inst;
    bus.reg_write  = c.rw;        bus.write_reg = c.wr;
    bus.write_data = c.wd;        bus.mem_read  = c.mr;
    bus.mem_write  = c.mw;        bus.mem_addr  = c.ma;
    bus.mem_data   = c.md;        bus.hlt       = c.hlt;
    bus.rd_en      = rd;
    if (rst) model_reset();
    else     model_step(c, rd);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Monitor: compares statistics every cycle and the head record on every pop.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        vectors++;
        if (bus.cycle_count !== 32'(s_cyc) || bus.inst_count !== 16'(s_inst) ||
            bus.drop_count !== 8'(s_drop) || bus.overflow !== s_ovf ||
            bus.halted !== s_halt || bus.timeout !== s_to || bus.rec_valid !== (s_cnt > 0)) begin
          miscompares++;
          $display("FAIL stats t=%0t got cyc=%0d inst=%0d drop=%0d ovf=%0b halt=%0b to=%0b vld=%0b exp cyc=%0d inst=%0d drop=%0d ovf=%0b halt=%0b to=%0b vld=%0b",
                   $time, bus.cycle_count, bus.inst_count, bus.drop_count, bus.overflow,
                   bus.halted, bus.timeout, bus.rec_valid, s_cyc, s_inst, s_drop, s_ovf,
                   s_halt, s_to, (s_cnt > 0));
        end
        if (bus.rec_valid !== 1'b1) begin
          vectors++;
          if ({bus.rec_kind, bus.rec_inum, bus.rec_pc, bus.rec_inst, bus.rec_reg,
               bus.rec_addr, bus.rec_value} !== 87'd0) begin
            miscompares++;
            $display("FAIL idle_zero t=%0t got kind=%0d inum=%0d pc=%0h exp all zero",
                     $time, bus.rec_kind, bus.rec_inum, bus.rec_pc);
          end
        end
        if (rst_n && bus.rd_en && bus.rec_valid) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL pop_unexpected t=%0t got inum=%0d exp no record", $time, bus.rec_inum);
          end else begin
            r = sb.pop_front();
            if (32'(bus.rec_kind) !== r.kind || 32'(bus.rec_inum) !== r.inum ||
                32'(bus.rec_pc) !== r.pc || 32'(bus.rec_inst) !== r.inst ||
                32'(bus.rec_reg) !== r.rreg || 32'(bus.rec_addr) !== r.addr ||
                32'(bus.rec_value) !== r.value) begin
              miscompares++;
              $display("FAIL record t=%0t got k=%0d n=%0d pc=%0h in=%0h r=%0d a=%0h v=%0h exp k=%0d n=%0d pc=%0h in=%0h r=%0d a=%0h v=%0h",
                       $time, bus.rec_kind, bus.rec_inum, bus.rec_pc, bus.rec_inst, bus.rec_reg,
                       bus.rec_addr, bus.rec_value, r.kind, r.inum, r.pc, r.inst, r.rreg,
                       r.addr, r.value);
            end
          end
        end
      end
    end
  end

  initial begin
    cin_t c;
    int   len, rdpct, hltpct;
    model_reset();
    drive(nop_c(), 1'b0, 1'b1);
    #3 mon_en = 1'b1;

    // Three NOPs, then the head is inum 0 with counters at 3.
    for (int i = 0; i < 3; i++) drive(nop_c(), 1'b0, 1'b0);
    drive(nop_c(), 1'b1, 1'b0);
    #1;
    chk("t1_cycle", bus.cycle_count, 32'd3);
    chk("t1_inst", 32'(bus.inst_count), 32'd3);
    chk("t1_kind", 32'(bus.rec_kind), 32'd0);
    for (int i = 0; i < 4; i++) drive(nop_c(), 1'b1, 1'b0);

    // LOAD classification.
    drive(nop_c(), 1'b0, 1'b1);
    c = nop_c(); c.rw = 1'b1; c.wr = 4'd5; c.wd = 16'h1234; c.mr = 1'b1; c.ma = 16'h0040;
    drive(c, 1'b0, 1'b0);
    drive(nop_c(), 1'b1, 1'b0);
    #1;
    chk("t2_kind", 32'(bus.rec_kind), 32'd2);
    chk("t2_reg", 32'(bus.rec_reg), 32'd5);
    chk("t2_value", 32'(bus.rec_value), 32'h1234);
    chk("t2_addr", 32'(bus.rec_addr), 32'h0040);

    // STORE then HALT; nothing captured afterwards, drain empties the FIFO.
    drive(nop_c(), 1'b0, 1'b1);
    c = nop_c(); c.mw = 1'b1; c.ma = 16'h0010; c.md = 16'hBEEF;
    drive(c, 1'b0, 1'b0);
    c = nop_c(); c.hlt = 1'b1; c.mw = 1'b1;
    drive(c, 1'b0, 1'b0);
    drive(rand_cin(50), 1'b0, 1'b0);
    #1;
    chk("t3_halted", 32'(bus.halted), 32'd1);
    chk("t3_head_store", 32'(bus.rec_kind), 32'd3);
    for (int i = 0; i < 3; i++) drive(rand_cin(50), 1'b1, 1'b0);
    #1;
    chk("t3_drained", 32'(bus.rec_valid), 32'd0);
    chk("t3_inst_frozen", 32'(bus.inst_count), 32'd2);

    // Overfill: 20 records into 16 slots, then in-order drain.
    drive(nop_c(), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive(rand_cin(0), 1'b0, 1'b0);
    drive(rand_cin(0), 1'b1, 1'b0);
    #1;
    chk("t4_drop", 32'(bus.drop_count), 32'd4);
    chk("t4_ovf", 32'(bus.overflow), 32'd1);
    chk("t4_inst", 32'(bus.inst_count), 32'd20);
    chk("t4_head", 32'(bus.rec_inum), 32'd0);
    for (int i = 0; i < 15; i++) drive(rand_cin(0), 1'b1, 1'b0);

    // Full FIFO with pop every cycle: no drops, occupancy stays at DEPTH.
    drive(nop_c(), 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) drive(rand_cin(0), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(rand_cin(0), 1'b1, 1'b0);
    drive(rand_cin(0), 1'b0, 1'b0);
    #1;
    chk("t5_no_drop", 32'(bus.drop_count), 32'd0);
    drive(rand_cin(0), 1'b0, 1'b0);
    #1;
    chk("t5_still_full", 32'(bus.drop_count), 32'd1);

    // Watchdog at LIMIT cycles, then reset clears everything.
    drive(nop_c(), 1'b0, 1'b1);
    for (int i = 0; i < 45; i++) drive(rand_cin(0), 1'b1, 1'b0);
    #1;
    chk("t6_timeout", 32'(bus.timeout), 32'd1);
    chk("t6_cycle", bus.cycle_count, 32'(LIMIT));
    chk("t6_inst", 32'(bus.inst_count), 32'(LIMIT));
    drive(rand_cin(0), 1'b1, 1'b1);
    drive(rand_cin(0), 1'b0, 1'b0);
    #1;
    chk("t6_rst_clear", {bus.cycle_count[15:0], bus.inst_count, 5'(bus.drop_count),
                         bus.overflow, bus.halted, bus.timeout}, 32'd0);
    chk("t6_rst_valid", 32'(bus.rec_valid), 32'd0);

    // Randomized phases with varied drain rates, halts, watchdog runs and mid-run resets.
    for (int p = 0; p < 8; p++) begin
      drive(nop_c(), 1'b0, 1'b1);
      len    = $urandom_range(10, 60);
      rdpct  = (p % 4 == 0) ? 0 : ((p % 4 == 1) ? 30 : ((p % 4 == 2) ? 70 : 100));
      hltpct = (p % 3 == 0) ? 0 : 3;
      for (int i = 0; i < len; i++) begin
        drive(rand_cin(hltpct), ($urandom_range(0, 99) < rdpct), ($urandom_range(0, 49) == 0));
      end
    end

    // Halt, then drain everything.
    c = nop_c(); c.hlt = 1'b1;
    drive(c, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(rand_cin(30), 1'b1, 1'b0);
    #1;
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_valid", 32'(bus.rec_valid), 32'd0);
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
